ascon_state_reader: RTL and testbench

ASCON_STATE_READER -- requirements
Module: ascon_state_reader

---
 rtl/ascon_state_reader_if.sv | 33 +++
 rtl/ascon_state_reader.sv | 134 +++++++++++++
 tb/tb_ascon_state_reader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_state_reader_if.sv
// ============================================================================
// Module   : ascon_state_reader_if
// Brief    : Masked-state capture and unmasked word-stream bundle.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ascon_state_reader_if #(
    parameter int D = 2,
    parameter int W = 64
);
    logic             done_in;
    logic [320*D-1:0] state_in;
    logic [W-1:0]     word_out;
    logic             word_valid;
    logic             word_ready;
    logic             word_last;
    logic             busy;
    logic             overrun;

    modport slave (
        input  done_in, state_in, word_ready,
        output word_out, word_valid, word_last, busy, overrun
    );

    modport master (
        output done_in, state_in, word_ready,
        input  word_out, word_valid, word_last, busy, overrun
    );
endinterface

`default_nettype wire

// File: rtl/ascon_state_reader.sv
// ============================================================================
// Module   : ascon_state_reader
// Brief    : Captures a D-share masked Ascon state and streams it unmasked as
//            five 64-bit words, most significant first. Optional macro
//            ASCON_READER_ZEROIZE_EN wipes the capture register after use.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ascon_state_reader #(
    parameter int D = 2,
    parameter int W = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ascon_state_reader_if.slave   bus
);
    localparam int         c_STATE_BITS = 320;
    localparam int         c_SHARE_BITS = c_STATE_BITS * D;
    localparam logic [2:0] c_LAST_IDX   = 3'd4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_SHARE_BITS-1:0] r_cap;
    logic [2:0]              r_idx;
    logic                    r_overrun;

    logic                    w_capture;
    logic                    w_xfer;
    logic                    w_final;
    logic                    w_overrun_set;
    logic                    w_valid;
    logic [c_STATE_BITS-1:0] w_plain;
    logic [W-1:0]            w_word;

    // Recombine the D shares of every state bit.
    for (genvar j = 0; j < c_STATE_BITS; j++) begin : g_unmask
        assign w_plain[j] = ^r_cap[D*j +: D];
    end

    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_xfer        = 1'b0;
        w_final       = 1'b0;
        w_overrun_set = 1'b0;
        w_valid       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.done_in) begin
                    w_capture    = 1'b1;
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                w_valid       = 1'b1;
                // A new completion while streaming, including the last beat, is an error.
                w_overrun_set = bus.done_in;
                if (bus.word_ready) begin
                    w_xfer = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_final      = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= 3'd0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_idx <= 3'd0;
            end else if (w_xfer && !w_final) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef ASCON_READER_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap <= '0;
        end else if (w_capture) begin
            r_cap <= bus.state_in;
        end else if (w_final) begin
            r_cap <= '0;
        end
    end
`else
    // No reset: the masked state simply persists until the next capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_cap <= bus.state_in;
        end
    end
`endif

    always_comb begin
        w_word = '0;
        case (r_idx)
            3'd0:    w_word = w_plain[319 -: W];
            3'd1:    w_word = w_plain[255 -: W];
            3'd2:    w_word = w_plain[191 -: W];
            3'd3:    w_word = w_plain[127 -: W];
            3'd4:    w_word = w_plain[63  -: W];
            default: w_word = '0;
        endcase
    end

    assign bus.word_out   = w_word;
    assign bus.word_valid = w_valid;
    assign bus.word_last  = w_valid && (r_idx == c_LAST_IDX);
    assign bus.busy       = w_valid;
    assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_ascon_state_reader.sv
// ============================================================================
// Module   : tb_ascon_state_reader
// Brief    : Randomized self-checking bench; expected words come from slicing
//            the unmasked 320-bit state directly.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ascon_state_reader;
    localparam int D = 2;
    localparam logic [319:0] c_S =
        320'h80400c06000000000001020304050607_08090a0b0c0d0e0f_0001020304050607_08090a0b0c0d0e0f;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic exp_ovr;
    logic [639:0] last_cap;

    ascon_state_reader_if #(.D(D), .W(64)) bus ();

    ascon_state_reader #(.D(D), .W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [639:0] pack(input logic [319:0] s0, input logic [319:0] s1);
        logic [639:0] p;
        for (int j = 0; j < 320; j++) begin
            p[2*j]   = s0[j];
            p[2*j+1] = s1[j];
        end
        return p;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic capture(input logic [319:0] s0, input logic [319:0] s1);
        @(negedge clk);
        bus.state_in   = pack(s0, s1);
        bus.done_in    = 1'b1;
        bus.word_ready = 1'b0;
        last_cap       = pack(s0, s1);
        @(posedge clk);
        #1;
        bus.done_in  = 1'b0;
        bus.state_in = pack(rand320(), rand320());
    endtask

    // Consume five words of the unmasked state `plain`.
    task automatic run_stream(input logic [319:0] plain, input int stall_idx, input int stall_n,
                              input bit rand_ready, input int ovr_idx);
        int k = 0;
        int cyc = 0;
        int stalled = 0;
        bit rdy;
        bit pulsed = 1'b0;
        while (k < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check("word_valid", bus.word_valid, 1'b1);
            check($sformatf("word%0d", k), bus.word_out, plain[319-64*k -: 64]);
            check("word_last", bus.word_last, (k == 4));
            check("busy", bus.busy, 1'b1);
            check("overrun", bus.overrun, exp_ovr);
            if (k == stall_idx && stalled < stall_n) begin
                rdy = 1'b0;
                stalled++;
            end else if (rand_ready && k != ovr_idx) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            bus.word_ready = rdy;
            if (k == ovr_idx && !pulsed) begin
                bus.done_in  = 1'b1;
                bus.state_in = pack(rand320(), rand320());
                pulsed       = 1'b1;
                exp_ovr      = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.done_in    = 1'b0;
            bus.word_ready = 1'b0;
            if (rdy) k++;
        end
        if (k < 5) check("stream_timeout", k, 5);
        @(negedge clk);
        check("idle_valid", bus.word_valid, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_last", bus.word_last, 1'b0);
        check("idle_overrun", bus.overrun, exp_ovr);
    endtask

    task automatic check_cap();
`ifdef ASCON_READER_ZEROIZE_EN
        check("cap_reg", dut.r_cap, '0);
`else
        check("cap_reg", dut.r_cap, last_cap);
`endif
    endtask

    initial begin
        logic [319:0] s;
        logic [319:0] m;
        n_checks       = 0;
        n_errors       = 0;
        exp_ovr        = 1'b0;
        last_cap       = '0;
        rst_n          = 1'b0;
        bus.done_in    = 1'b0;
        bus.word_ready = 1'b0;
        bus.state_in   = '0;
        #3;
        check("rst_valid", bus.word_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_last", bus.word_last, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain share0, then inverted shares to exercise recombination.
        capture(c_S, '0);
        run_stream(c_S, -1, 0, 1'b0, -1);
        check_cap();
        capture(~c_S, '1);
        run_stream(c_S, -1, 0, 1'b0, -1);
        check_cap();

        // Back-pressure at index 2.
        capture(c_S, '0);
        run_stream(c_S, 2, 3, 1'b0, -1);

        // Completion pulse while streaming at index 1.
        capture(c_S, '0);
        run_stream(c_S, -1, 0, 1'b0, 1);
        check_cap();

        for (int t = 0; t < 4; t++) begin
            s = rand320();
            m = rand320();
            capture(s ^ m, m);
            run_stream(s, -1, 0, 1'b1, -1);
            check_cap();
        end

        // Completion coinciding with the final transfer.
        capture(c_S, '0);
        run_stream(c_S, -1, 0, 1'b0, 4);
        check_cap();

        // Reset in the middle of the stream.
        capture(c_S, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.word_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.word_ready = 1'b0;
        end
        @(negedge clk);
        check("pre_reset_word3", bus.word_out, c_S[127:64]);
        rst_n = 1'b0;
        #1;
        check("abort_valid", bus.word_valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_last", bus.word_last, 1'b0);
        check("abort_overrun", bus.overrun, 1'b0);
        exp_ovr = 1'b0;
`ifdef ASCON_READER_ZEROIZE_EN
        check("abort_cap", dut.r_cap, '0);
`else
        check("abort_cap", dut.r_cap, last_cap);
`endif
        @(negedge clk);
        rst_n          = 1'b1;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_valid", bus.word_valid, 1'b0);
        end
        bus.word_ready = 1'b0;

        capture(c_S, '0);
        run_stream(c_S, -1, 0, 1'b1, -1);
        check_cap();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
